simple_logic_deser: RTL
=======================

Name: simple_logic_deser

Overview:
- Downstream consumer of the single-bit registered `out` stream produced by the simple_logic_ff stage.
- Packs successive enabled samples, LSB-first, into a WIDTH-bit word.
- Presents the word on a valid/ready output port, together with its population count.
- One partial-word shift register plus one output holding register, so filling continues while a word awaits consumption.

Parameters:
- WIDTH, 8, number of serial bits per output word (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), width of ones_cnt; derived, not to be overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  1  serial data bit (the upstream `out`).
- din_en  input  1  sample din this cycle.
- word_ready  input  1  consumer accepts word this cycle.
- word  output  WIDTH  assembled word; bit i = i-th accepted bit.
- word_valid  output  1  word holds an unconsumed word.
- ones_cnt  output  CNT_W  number of 1 bits in word.
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (clk edge with reset=1):
  - word=0, word_valid=0, ones_cnt=0, overrun=0.
  - Shift register=0, bit counter=0.
  - Reset overrides every other input in the same cycle.
  - Reset mid-word discards the partial bits.
- Fill path:
  - Each cycle with din_en=1, din is written at shift position bit_cnt.
  - bit_cnt increments; it wraps from WIDTH-1 to 0.
  - din_en=0 holds all fill state.
- Completion: the cycle in which bit WIDTH-1 is accepted. The completed word is {din, shift[WIDTH-2:0]}.
- Output register, two states, EMPTY (word_valid=0) and FULL (word_valid=1):
  - EMPTY + completion -> load word and ones_cnt; FULL next cycle. Latency: word_valid high one cycle after the WIDTH-th accepted bit.
  - FULL + word_ready, no completion -> EMPTY. word retains its last value; ones_cnt retains its value.
  - FULL + word_ready + completion (same cycle) -> new word loaded, stays FULL, no overrun.
  - FULL + no word_ready + completion -> new word dropped, old word unchanged, overrun set to 1.
  - overrun stays set until reset.
- Filling continues regardless of output state. A dropped word still resets bit_cnt to 0.
- word_ready while EMPTY has no effect.
- ones_cnt is registered together with word; never combinational from the shift register.
- word, word_valid and ones_cnt do not depend combinationally on word_ready.

Optional Feature:
- Macro: SIMPLE_LOGIC_DESER_PARITY_EN.
- With macro defined:
  - Extra output port word_parity (1 bit) = XOR of all bits of the loaded word.
  - Registered alongside word; reset value 0.
- Without macro: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package simple_logic_pkg holds:
  - DESER_WIDTH_DEFAULT = 8.
  - Output-state enum {ST_EMPTY, ST_FULL}.
- Sub-module: deser_popcount, a combinational popcount of a WIDTH-bit vector into CNT_W bits. It feeds the ones_cnt register.

Test Plan (WIDTH=8):
1. Reset held 2 cycles with random din/din_en -> word=0x00, word_valid=0, ones_cnt=0, overrun=0.
2. din_en=1, din=1,0,1,1,0,0,0,1 on consecutive cycles, word_ready=1 -> word_valid=1 on the cycle after the 8th bit, word=0x8D, ones_cnt=4. Under PARITY_EN, word_parity=0.
3. Same 8 bits with din_en=0 gaps of 1-3 cycles between them -> identical word=0x8D. word_valid stays 0 until one cycle after the last accepted bit.
4. word_ready=0; send 0xFF then 0x01 -> word stays 0xFF, ones_cnt=8, overrun=1. Then pulse word_ready -> word_valid=0. overrun stays 1 until reset.
5. word_ready asserted exactly on the completion cycle of a second word (0x3C after 0xA5) -> word_valid stays 1, word=0x3C, ones_cnt=4, overrun=0.
6. Five bits of 1 accepted, reset for 1 cycle, then bits 0,1,0,0,0,0,0,0 -> word=0x02, ones_cnt=1; no residue from the pre-reset bits.

Source files
------------

// File: rtl/simple_logic_pkg.sv
// Shared definitions for the simple_logic deserializer: default word width and output-state enum.
package simple_logic_pkg;

   localparam int unsigned DESER_WIDTH_DEFAULT = 8;

   typedef enum logic [0:0] {
      ST_EMPTY,
      ST_FULL
   } out_state_e;

   function automatic int unsigned deser_cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/simple_logic_deser_if.sv
// Serial-in / word-out bundle for simple_logic_deser.
// Optional word_parity signal is present when SIMPLE_LOGIC_DESER_PARITY_EN is defined.
interface simple_logic_deser_if
   import simple_logic_pkg::*;
#(
   parameter int unsigned WIDTH = DESER_WIDTH_DEFAULT,
   parameter int unsigned CNT_W = deser_cnt_width(WIDTH)
);

   logic             din;
   logic             din_en;
   logic             word_ready;
   logic [WIDTH-1:0] word;
   logic             word_valid;
   logic [CNT_W-1:0] ones_cnt;
   logic             overrun;
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
   logic             word_parity;
`endif

   // Producer of serial bits and consumer of words.
   modport master (
      output din,
      output din_en,
      output word_ready,
      input  word,
      input  word_valid,
      input  ones_cnt,
      input  overrun
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
      ,
      input  word_parity
`endif
   );

   modport slave (
      input  din,
      input  din_en,
      input  word_ready,
      output word,
      output word_valid,
      output ones_cnt,
      output overrun
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
      ,
      output word_parity
`endif
   );

endinterface

// File: rtl/deser_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module deser_popcount #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [CNT_W-1:0] cnt_o
);

   always_comb begin
      cnt_o = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt_o = cnt_o + CNT_W'(vec_i[i]);
      end
   end

endmodule

// File: rtl/simple_logic_deser.sv
// LSB-first serial-to-parallel packer with a one-word valid/ready holding register.
// Define SIMPLE_LOGIC_DESER_PARITY_EN to add the registered word_parity output.
module simple_logic_deser
   import simple_logic_pkg::*;
#(
   parameter int unsigned WIDTH = DESER_WIDTH_DEFAULT
) (
   input logic                 clk,
   input logic                 reset,
   simple_logic_deser_if.slave bus
);

   localparam int unsigned CNT_W = deser_cnt_width(WIDTH);
   localparam int unsigned BIT_W = $clog2(WIDTH);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

   // Fill path state
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

   // Output holding register state
   out_state_e       state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             overrun_q, overrun_d;
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic             complete;
   logic [WIDTH-1:0] new_word;
   logic [CNT_W-1:0] new_cnt;
   logic             load;

   // new_word already contains the bit accepted this cycle, so on completion it is the full word.
   always_comb begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      complete  = 1'b0;
      if (bus.din_en) begin
         shift_d[bit_cnt_q] = bus.din;
         if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            complete  = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
      end
      new_word = shift_d;
   end

   deser_popcount #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_popcount (
      .vec_i (new_word),
      .cnt_o (new_cnt)
   );

   always_comb begin
      state_d   = state_q;
      overrun_d = overrun_q;
      load      = 1'b0;
      unique case (state_q)
         ST_EMPTY: begin
            if (complete) begin
               load    = 1'b1;
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (complete) begin
               if (bus.word_ready) begin
                  load = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end else if (bus.word_ready) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (load) begin
         word_d = new_word;
         cnt_d  = new_cnt;
      end
   end

`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
   always_comb begin
      parity_d = parity_q;
      if (load) begin
         parity_d = ^new_word;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
         state_q   <= ST_EMPTY;
         word_q    <= '0;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         state_q   <= state_d;
         word_q    <= word_d;
         cnt_q     <= cnt_d;
         overrun_q <= overrun_d;
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign bus.word       = word_q;
   assign bus.word_valid = (state_q == ST_FULL);
   assign bus.ones_cnt   = cnt_q;
   assign bus.overrun    = overrun_q;
`ifdef SIMPLE_LOGIC_DESER_PARITY_EN
   assign bus.word_parity = parity_q;
`endif

endmodule
